// File: rtl/switch_pkg.sv
// Shared defaults for the multi-channel switch debouncer.
// The optional long-press detector is enabled by defining SWITCH_HOLD_EN.
package switch_pkg;

  localparam int unsigned DivCountDefault    = 256;
  localparam int unsigned StableCountDefault = 8;
  localparam int unsigned HoldTicksDefault   = 1024;
  localparam bit          ActiveLowDefault   = 1'b1;

  // Raw pin level seen while the switch is released.
  function automatic logic idle_raw_level(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, stable-sample counter, level and edge strobes.
// Long-press detection is built only when SWITCH_HOLD_EN is defined.
module debounce_channel
  import switch_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = StableCountDefault,
  parameter bit          ACTIVE_LOW   = ActiveLowDefault,
  parameter int unsigned HOLD_TICKS   = HoldTicksDefault
) (
  input  logic sys_clock,
  input  logic sys_reset,
  input  logic tick_i,
  input  logic switch_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int unsigned     CntW    = $clog2(STABLE_COUNT);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_COUNT - 1);
  localparam logic            IdleRaw = idle_raw_level(ACTIVE_LOW);

  if (STABLE_COUNT < 2 || HOLD_TICKS < 1) begin : gen_bad_cfg
    $error("debounce_channel: invalid parameter set");
  end

  logic [1:0]      sync_q;
  logic            sample;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // Reset loads the released pin level so leaving reset never looks like a press.
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      sync_q <= {2{IdleRaw}};
    end else begin
      sync_q <= {sync_q[0], switch_i};
    end
  end

  assign sample = sync_q[1] ^ ACTIVE_LOW;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick_i) begin
      if (sample == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        cnt_d     = '0;
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef SWITCH_HOLD_EN
  localparam int unsigned      HoldW   = $clog2(HOLD_TICKS + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_TICKS);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             hold_q, hold_d;

  // Saturating at HoldMax gives one strobe per press with no auto-repeat.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_d     = 1'b0;
    if (!level_q) begin
      hold_cnt_d = '0;
    end else if (tick_i && hold_cnt_q != HoldMax) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      hold_d     = (hold_cnt_q == HoldMax - 1'b1);
    end
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign hold_o = hold_q;
`else
  assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce_multi.sv
// Multi-channel switch debouncer: shared sample-tick prescaler plus one debounce_channel per pin.
// Define SWITCH_HOLD_EN to enable the per-channel long-press strobe on hold_pulse.
module switch_debounce_multi
  import switch_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned DIV_COUNT    = DivCountDefault,
  parameter int unsigned STABLE_COUNT = StableCountDefault,
  parameter bit          ACTIVE_LOW   = ActiveLowDefault,
  parameter int unsigned HOLD_TICKS   = HoldTicksDefault
) (
  input  logic                sys_clock,
  input  logic                sys_reset,
  input  logic [CHANNELS-1:0] switch_in,
  output logic [CHANNELS-1:0] switch_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] hold_pulse
);

  localparam int unsigned       PrescW   = $clog2(DIV_COUNT);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(DIV_COUNT - 1);

  if (CHANNELS < 1 || DIV_COUNT < 2 || STABLE_COUNT < 2 || HOLD_TICKS < 1) begin : gen_bad_cfg
    $error("switch_debounce_multi: invalid parameter set");
  end

  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;

  always_comb begin
    tick    = (presc_q == PrescMax);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_chan
    debounce_channel #(
      .STABLE_COUNT (STABLE_COUNT),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .HOLD_TICKS   (HOLD_TICKS)
    ) u_chan (
      .sys_clock (sys_clock),
      .sys_reset (sys_reset),
      .tick_i    (tick),
      .switch_i  (switch_in[i]),
      .level_o   (switch_out[i]),
      .press_o   (press_pulse[i]),
      .release_o (release_pulse[i]),
      .hold_o    (hold_pulse[i])
    );
  end

endmodule

// File: tb/tb_switch_debounce_multi.sv
// Self-checking bench for switch_debounce_multi against a sample-history reference model.
// Hold expectations follow SWITCH_HOLD_EN.
module tb_switch_debounce_multi;

  localparam int Ch     = 4;
  localparam int Div    = 4;
  localparam int Stable = 3;
  localparam int Hold   = 5;

  logic          sys_clock = 1'b0;
  logic          sys_reset;
  logic [Ch-1:0] switch_in;
  logic [Ch-1:0] switch_out;
  logic [Ch-1:0] press_pulse;
  logic [Ch-1:0] release_pulse;
  logic [Ch-1:0] hold_pulse;

  int checks = 0;
  int errors = 0;

  always #5 sys_clock = ~sys_clock;

  switch_debounce_multi #(
    .CHANNELS     (Ch),
    .DIV_COUNT    (Div),
    .STABLE_COUNT (Stable),
    .ACTIVE_LOW   (1'b1),
    .HOLD_TICKS   (Hold)
  ) dut (
    .sys_clock     (sys_clock),
    .sys_reset     (sys_reset),
    .switch_in     (switch_in),
    .switch_out    (switch_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .hold_pulse    (hold_pulse)
  );

  // Reference model: pressed-level pipe of raw pins, last Stable tick samples, hold tick counts.
  logic [Ch-1:0] m_pipe[$];
  logic [Ch-1:0] m_ticks[$];
  logic [Ch-1:0] m_out   = '0;
  logic [Ch-1:0] m_press = '0;
  logic [Ch-1:0] m_rel   = '0;
  logic [Ch-1:0] m_hold  = '0;
  int            m_cyc   = 0;
  int            m_held[Ch];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [Ch-1:0] s;
    logic [Ch-1:0] prev;
    bit            tick;
    bit            flip;
    if (sys_reset) begin
      m_pipe  = '{'0, '0};
      m_ticks.delete();
      m_cyc   = 0;
      m_out   = '0;
      m_press = '0;
      m_rel   = '0;
      m_hold  = '0;
      foreach (m_held[i]) m_held[i] = 0;
      return;
    end
    s = m_pipe.pop_front();
    m_pipe.push_back(~switch_in);
    tick  = (m_cyc % Div) == Div - 1;
    m_cyc++;
    prev    = m_out;
    m_press = '0;
    m_rel   = '0;
    m_hold  = '0;
    if (tick) begin
      m_ticks.push_back(s);
      if (m_ticks.size() > Stable) void'(m_ticks.pop_front());
    end
    for (int i = 0; i < Ch; i++) begin
      if (!prev[i]) begin
        m_held[i] = 0;
      end else if (tick && m_held[i] < Hold) begin
        m_held[i]++;
`ifdef SWITCH_HOLD_EN
        if (m_held[i] == Hold) m_hold[i] = 1'b1;
`endif
      end
      if (tick && m_ticks.size() == Stable) begin
        flip = 1'b1;
        foreach (m_ticks[k]) if (m_ticks[k][i] == prev[i]) flip = 1'b0;
        if (flip) begin
          m_out[i]   = ~prev[i];
          m_press[i] = ~prev[i];
          m_rel[i]   = prev[i];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge sys_clock);
    model_edge();
    @(negedge sys_clock);
    check("switch_out", switch_out, m_out);
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_rel);
    check("hold_pulse", hold_pulse, m_hold);
  endtask

  task automatic wait_level(input int ch, input logic lvl, input int bound, output int lat);
    lat = bound + 1;
    for (int n = 1; n <= bound; n++) begin
      step();
      if (switch_out[ch] === lvl) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int            lat;
    int            holds;
    int            hold_lat;
    int            rate;
    logic [Ch-1:0] strobes;

    foreach (m_held[i]) m_held[i] = 0;
    sys_reset = 1'b1;
    switch_in = '1;
    repeat (3) step();
    check("reset_out", switch_out, 0);
    check("reset_strobes", press_pulse | release_pulse | hold_pulse, 0);

    // Idle after reset: no spurious press.
    sys_reset = 1'b0;
    strobes   = '0;
    repeat (100) begin
      step();
      strobes |= press_pulse | release_pulse | hold_pulse;
    end
    check("idle_no_strobes", strobes, 0);
    check("idle_out", switch_out, 0);

    // Clean press on ch0.
    switch_in[0] = 1'b0;
    wait_level(0, 1'b1, 40, lat);
    check("ch0_rise_window", (lat >= 11 && lat <= 14), 1);
    check("ch0_press_at_rise", press_pulse, 4'b0001);
    step();
    check("ch0_press_one_cycle", press_pulse[0], 0);

    // Bouncing ch1, then a clean press after settling released.
    repeat (4) begin
      switch_in[1] = 1'b0;
      repeat (6) step();
      switch_in[1] = 1'b1;
      repeat (3) step();
    end
    repeat (20) step();
    check("ch1_settled_released", switch_out[1], 0);
    switch_in[1] = 1'b0;
    wait_level(1, 1'b1, 40, lat);
    check("ch1_rise_window", (lat >= 11 && lat <= 14), 1);

    // Simultaneous press on ch2/ch3, then release ch2 alone.
    switch_in[3:2] = 2'b00;
    wait_level(2, 1'b1, 40, lat);
    check("ch23_same_cycle", switch_out[3:2], 2'b11);
    check("ch23_two_strobes", press_pulse[3:2], 2'b11);
    switch_in[2] = 1'b1;
    wait_level(2, 1'b0, 40, lat);
    check("ch2_release_only", release_pulse, 4'b0100);
    check("ch2_release_no_press", press_pulse, 0);
    check("ch3_still_pressed", switch_out[3], 1);

    // One-cycle reset while ch0 is pressed.
    check("ch0_pressed_before_reset", switch_out[0], 1);
    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0;
    check("reset_clears_out", switch_out, 0);
    check("reset_no_release", release_pulse, 0);
    wait_level(0, 1'b1, 40, lat);
    check("ch0_rerise_window", (lat >= 11 && lat <= 14), 1);

    // Long press on ch0.
    holds    = 0;
    hold_lat = 0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (hold_pulse[0]) begin
        holds++;
        if (hold_lat == 0) hold_lat = n;
      end
    end
`ifdef SWITCH_HOLD_EN
    check("hold_once", holds, 1);
    check("hold_latency", hold_lat, 20);
`else
    check("hold_never", holds, 0);
`endif

    // Randomised segments with varying toggle rates and occasional resets.
    for (int seg = 0; seg < 20; seg++) begin
      rate = $urandom_range(3, 40);
      for (int n = 0; n < 40; n++) begin
        for (int c = 0; c < Ch; c++) begin
          if ($urandom_range(0, rate - 1) == 0) switch_in[c] = ~switch_in[c];
        end
        sys_reset = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    sys_reset = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
